regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (WE3/A3/WD3) between two writeback requesters: req0 = ALU result, req1 = load data.
- Uses valid/ready handshakes with round-robin arbitration and one registered output stage.
- Suppresses writes to x0.
- Flags in-flight writes that match the current read addresses, and provides the data for forwarding.

Parameters:
DATA_W, 32, width of write data / register word
ADDR_W, 5, register index width (32 registers)
CNT_W, 16, width of the saturating conflict counter

Ports:
CLK  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  when 1, no grants are issued this cycle
req0_valid  input  1  ALU writeback request
req0_addr  input  ADDR_W  ALU destination register
req0_data  input  DATA_W  ALU result
req0_ready  output  1  req0 granted this cycle (combinational)
req1_valid  input  1  load writeback request
req1_addr  input  ADDR_W  load destination register
req1_data  input  DATA_W  load data
req1_ready  output  1  req1 granted this cycle (combinational)
WE3  output  1  register file write enable (registered)
A3  output  ADDR_W  register file write address (registered)
WD3  output  DATA_W  register file write data (registered)
last_grant  output  1  requester id of the most recent grant (registered)
rs1_addr  input  ADDR_W  current read address A1
rs2_addr  input  ADDR_W  current read address A2
fwd1_hit  output  1  pending write matches rs1_addr
fwd2_hit  output  1  pending write matches rs2_addr
fwd_data  output  DATA_W  equals WD3, data to forward
conflict_cnt  output  CNT_W  count of cycles with both requesters valid

Behaviour:
- Reset (rst=1 at posedge):
  - WE3=0, A3=0, WD3=0, last_grant=0, rr_ptr=0, conflict_cnt=0.
  - req*_ready is forced to 0 in any cycle where rst=1.
- Grant logic (combinational, when stall=0 and rst=0):
  - Only reqK_valid: grant K.
  - Both valid: grant the requester indicated by rr_ptr.
  - Neither valid: no grant.
  - reqK_ready = grant to K. At most one ready is high per cycle.
  - A transfer occurs when reqK_valid && reqK_ready.
- Handshake rules:
  - A requester holds valid, addr and data stable until ready.
  - ready never depends on the requester's own data.
- rr_ptr update: flips to the non-granted requester only on cycles where both were valid and a grant occurred. Otherwise it holds.
- stall=1: both readies are 0, no grant, and WE3=0 on the next cycle. rr_ptr and last_grant hold.
- Output stage (1-cycle latency, transfer at edge N appears on WE3/A3/WD3 during cycle N+1):
  - Grant at posedge: A3 <= granted addr, WD3 <= granted data, last_grant <= id, WE3 <= (granted addr != 0).
  - No grant: WE3 <= 0; A3 and WD3 hold their previous values.
- x0 writes: handshake completes normally (ready=1, grant consumed, rr_ptr updates), but WE3 stays 0.
- Forwarding:
  - fwd1_hit = WE3 && (A3 == rs1_addr) && (rs1_addr != 0). fwd2_hit is the same with rs2_addr.
  - fwd_data = WD3.
  - All three are purely combinational from registered state and rs*_addr.
- conflict_cnt:
  - Increments on every non-reset cycle where req0_valid && req1_valid, whether or not stall is set.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Back-to-back transfers: a new grant is allowed every cycle. Sustained both-valid traffic alternates 0,1,0,1...
- Reset mid-operation: any transfer in the reset cycle is discarded. WE3=0 on the following cycle.

Optional Feature:
- Macro: WB_ARB_FIXED_PRIO_EN.
- Defined:
  - req1 (load) always wins when both are valid.
  - rr_ptr is removed and has no effect.
  - All other behaviour is unchanged.
- Undefined: round-robin arbitration as described under Behaviour.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 with no requests -> WE3=0, A3=0, WD3=0, conflict_cnt=0, both readies 0.
- Single request: req0 valid, addr=3, data=0x10 -> req0_ready=1 the same cycle; next cycle WE3=1, A3=3, WD3=0x10; following cycle WE3=0 with A3/WD3 held.
- Contention, round-robin: both valid for 4 cycles, req0 addr=5/data=6, req1 addr=6/data=0xA ->
  - Grants go 0,1,0,1.
  - last_grant sequence 0,1,0,1.
  - conflict_cnt=4.
  - With WB_ARB_FIXED_PRIO_EN defined, all four grants go to req1.
- x0 suppression: req1 addr=0, data=0xFFFF -> req1_ready=1; next cycle WE3=0, fwd1_hit=0 with rs1_addr=0.
- Forwarding: grant req0 addr=7, data=0x55; next cycle rs1_addr=7, rs2_addr=8 -> fwd1_hit=1, fwd2_hit=0, fwd_data=0x55.
- Stall and saturation:
  - stall=1 with both requesters valid -> no readies, WE3=0 next cycle, rr_ptr unchanged, conflict_cnt still increments.
  - With CNT_W=2, holding both valid for 5 cycles -> conflict_cnt stops at 3.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (ALU, load) and the shared register file write port.
// The arbiter connects through the slave modport.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              WE3;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  WE3, A3, WD3
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output WE3, A3, WD3
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and load writeback.
// Define WB_ARB_FIXED_PRIO_EN to make the load requester always win contention instead.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 stall,
  regfile_wb_arbiter_if.slave  wb,
  input  logic [ADDR_W-1:0]    rs1_addr,
  input  logic [ADDR_W-1:0]    rs2_addr,
  output logic                 last_grant,
  output logic                 fwd1_hit,
  output logic                 fwd2_hit,
  output logic [DATA_W-1:0]    fwd_data,
  output logic [CNT_W-1:0]     conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              both;
  logic              gnt0;
  logic              gnt1;
  logic              grant;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;

  logic              we3_q, we3_d;
  logic [ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifndef WB_ARB_FIXED_PRIO_EN
  logic              rr_ptr_q, rr_ptr_d;
`endif

  // Grants never look at requester data, only valid bits, stall, reset and the pointer.
  always_comb begin
    both = wb.req0_valid & wb.req1_valid;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && !stall) begin
      if (both) begin
`ifdef WB_ARB_FIXED_PRIO_EN
        gnt1 = 1'b1;
`else
        gnt0 = ~rr_ptr_q;
        gnt1 = rr_ptr_q;
`endif
      end else begin
        gnt0 = wb.req0_valid;
        gnt1 = wb.req1_valid;
      end
    end
    grant  = gnt0 | gnt1;
    g_addr = gnt1 ? wb.req1_addr : wb.req0_addr;
    g_data = gnt1 ? wb.req1_data : wb.req0_data;
  end

  always_comb begin
    we3_d        = 1'b0;
    a3_d         = a3_q;
    wd3_d        = wd3_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
`ifndef WB_ARB_FIXED_PRIO_EN
    rr_ptr_d     = rr_ptr_q;
    if (both && grant) rr_ptr_d = gnt0;
`endif
    if (grant) begin
      we3_d        = (g_addr != '0);
      a3_d         = g_addr;
      wd3_d        = g_data;
      last_grant_d = gnt1;
    end
    if (both && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      we3_q        <= 1'b0;
      a3_q         <= '0;
      wd3_q        <= '0;
      last_grant_q <= 1'b0;
      cnt_q        <= '0;
`ifndef WB_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= 1'b0;
`endif
    end else begin
      we3_q        <= we3_d;
      a3_q         <= a3_d;
      wd3_q        <= wd3_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
`ifndef WB_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign wb.req0_ready = gnt0;
  assign wb.req1_ready = gnt1;
  assign wb.WE3        = we3_q;
  assign wb.A3         = a3_q;
  assign wb.WD3        = wd3_q;
  assign last_grant    = last_grant_q;
  assign conflict_cnt  = cnt_q;

  // x0 is never written, so a registered x0 entry can never forward.
  assign fwd1_hit = we3_q && (a3_q == rs1_addr) && (rs1_addr != '0);
  assign fwd2_hit = we3_q && (a3_q == rs2_addr) && (rs2_addr != '0);
  assign fwd_data = wd3_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a reference model pushes expected write-port state to a
// scoreboard queue each cycle; a second instance with CNT_W=2 covers counter saturation.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          rst;
  logic          rst_s;
  logic          stall;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;

  logic          last_grant, fwd1_hit, fwd2_hit;
  logic [DW-1:0] fwd_data;
  logic [15:0]   conflict_cnt;

  logic          last_grant_s, fwd1_hit_s, fwd2_hit_s;
  logic [DW-1:0] fwd_data_s;
  logic [1:0]    conflict_cnt_s;

  always #5 CLK = ~CLK;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus_s ();

  assign bus_s.req0_valid = bus.req0_valid;
  assign bus_s.req0_addr  = bus.req0_addr;
  assign bus_s.req0_data  = bus.req0_data;
  assign bus_s.req1_valid = bus.req1_valid;
  assign bus_s.req1_addr  = bus.req1_addr;
  assign bus_s.req1_data  = bus.req1_data;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(16)) dut (
    .CLK(CLK), .rst(rst), .stall(stall), .wb(bus.slave),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .last_grant(last_grant), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd_data(fwd_data), .conflict_cnt(conflict_cnt)
  );

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) dut_sat (
    .CLK(CLK), .rst(rst_s), .stall(stall), .wb(bus_s.slave),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .last_grant(last_grant_s), .fwd1_hit(fwd1_hit_s), .fwd2_hit(fwd2_hit_s),
    .fwd_data(fwd_data_s), .conflict_cnt(conflict_cnt_s)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          lg;
    logic [15:0]   cnt;
    logic [1:0]    cnt_s;
  } exp_t;

  exp_t sbq[$];

  int vectors = 0;
  int errors  = 0;

  logic          m_rr;
  logic          m_lg;
  logic [AW-1:0] m_a3;
  logic [DW-1:0] m_wd3;
  logic [15:0]   m_cnt;
  logic [1:0]    m_cnt_s;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic st, input logic r,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    logic eg0, eg1, bth;
    exp_t e, got;
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    stall = st; rst = r; rs1_addr = r1; rs2_addr = r2;
    #1;
    bth = v0 && v1;
    eg0 = 1'b0; eg1 = 1'b0;
    if (!r && !st) begin
      if (bth) begin
`ifdef WB_ARB_FIXED_PRIO_EN
        eg1 = 1'b1;
`else
        if (m_rr) eg1 = 1'b1;
        else      eg0 = 1'b1;
`endif
      end else begin
        eg0 = v0; eg1 = v1;
      end
    end
    check("req0_ready", {63'd0, bus.req0_ready}, {63'd0, eg0});
    check("req1_ready", {63'd0, bus.req1_ready}, {63'd0, eg1});

    if (r) begin
      e.we = 1'b0; e.a = '0; e.d = '0; e.lg = 1'b0; e.cnt = '0;
      m_rr = 1'b0;
    end else begin
      if (eg0 || eg1) begin
        e.a  = eg1 ? a1 : a0;
        e.d  = eg1 ? d1 : d0;
        e.we = (e.a != '0);
        e.lg = eg1;
        if (bth) m_rr = eg0;
      end else begin
        e.we = 1'b0; e.a = m_a3; e.d = m_wd3; e.lg = m_lg;
      end
      e.cnt = (bth && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt;
    end
    if (rst_s) e.cnt_s = 2'd0;
    else       e.cnt_s = (bth && m_cnt_s != 2'd3) ? m_cnt_s + 2'd1 : m_cnt_s;
    m_a3 = e.a; m_wd3 = e.d; m_lg = e.lg; m_cnt = e.cnt; m_cnt_s = e.cnt_s;
    sbq.push_back(e);

    @(posedge CLK);
    #1;
    if (sbq.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      got = sbq.pop_front();
      check("WE3",            {63'd0, bus.WE3},      {63'd0, got.we});
      check("A3",             {59'd0, bus.A3},       {59'd0, got.a});
      check("WD3",            {32'd0, bus.WD3},      {32'd0, got.d});
      check("last_grant",     {63'd0, last_grant},   {63'd0, got.lg});
      check("conflict_cnt",   {48'd0, conflict_cnt}, {48'd0, got.cnt});
      check("conflict_cnt_s", {62'd0, conflict_cnt_s}, {62'd0, got.cnt_s});
      check("fwd1_hit", {63'd0, fwd1_hit}, {63'd0, (got.we && got.a == r1 && r1 != '0)});
      check("fwd2_hit", {63'd0, fwd2_hit}, {63'd0, (got.we && got.a == r2 && r2 != '0)});
      check("fwd_data", {32'd0, fwd_data}, {32'd0, got.d});
    end
  endtask

  task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, r1, r2);
  endtask

  initial begin
    m_rr = 1'b0; m_lg = 1'b0; m_a3 = '0; m_wd3 = '0; m_cnt = '0; m_cnt_s = '0;
    rst_s = 1'b1;

    // reset for two cycles, then quiet
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 5'd0, 5'd0);
    step(1'b1, 5'd9, 32'h99, 1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 5'd0, 5'd0);
    rst_s = 1'b0;
    idle(5'd0, 5'd0);

    // single ALU request, then hold
    step(1'b1, 5'd3, 32'h10, 1'b0, '0, '0, 1'b0, 1'b0, 5'd3, 5'd0);
    idle(5'd3, 5'd0);

    // contention: alternating grants
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'd5, 32'h6, 1'b1, 5'd6, 32'hA, 1'b0, 1'b0, 5'd5, 5'd6);
    idle(5'd0, 5'd0);

    // x0 write is accepted but suppressed
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 1'b0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // forwarding
    step(1'b1, 5'd7, 32'h55, 1'b0, '0, '0, 1'b0, 1'b0, 5'd7, 5'd8);
    step(1'b0, '0, '0, 1'b1, 5'd8, 32'h77, 1'b0, 1'b0, 5'd7, 5'd8);

    // stall with both valid, then release: pointer must not have moved
    step(1'b1, 5'd11, 32'hB1, 1'b1, 5'd12, 32'hC2, 1'b1, 1'b0, 5'd11, 5'd12);
    step(1'b1, 5'd11, 32'hB1, 1'b1, 5'd12, 32'hC2, 1'b1, 1'b0, 5'd11, 5'd12);
    step(1'b1, 5'd11, 32'hB1, 1'b1, 5'd12, 32'hC2, 1'b0, 1'b0, 5'd11, 5'd12);
    step(1'b0, '0, '0, 1'b1, 5'd12, 32'hC2, 1'b0, 1'b0, 5'd11, 5'd12);

    // saturation on the narrow counter
    rst_s = 1'b1;
    idle(5'd0, 5'd0);
    rst_s = 1'b0;
    for (int i = 0; i < 5; i++)
      step(1'b1, 5'd13, 32'h1300 + i, 1'b1, 5'd14, 32'h1400 + i, 1'b0, 1'b0, 5'd13, 5'd14);

    // reset in the middle of traffic discards the transfer
    step(1'b1, 5'd15, 32'hDEAD, 1'b1, 5'd16, 32'hBEEF, 1'b0, 1'b1, 5'd15, 5'd16);
    step(1'b1, 5'd15, 32'hDEAD, 1'b0, '0, '0, 1'b0, 1'b0, 5'd15, 5'd16);
    idle(5'd15, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
